zeroheti_apb_timer: RTL and testbench
=====================================

# zeroheti_apb_timer

RISC-V machine timer peripheral that sits directly downstream of the core's OBI-to-APB bridge, on the APB peripheral segment. It provides a 64-bit free-running `mtime` counter, a 64-bit `mtimecmp` compare register, a control register and a level timer interrupt. The interrupt feeds the CLIC timer line. All registers are accessed as zero-wait-state APB slave registers.

## Interface
- `AddrWidth`, 32: APB address width; only `paddr_i[4:0]` is decoded.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `psel_i`  in  1  APB select.
- `penable_i`  in  1  APB access phase.
- `pwrite_i`  in  1  1 = write.
- `paddr_i`  in  AddrWidth  byte address.
- `pwdata_i`  in  32  write data.
- `pstrb_i`  in  4  write byte strobes.
- `prdata_o`  out  32  read data; valid in the access phase, 0 otherwise.
- `pready_o`  out  1  tied 1 (zero wait states).
- `pslverr_o`  out  1  error response, valid in the access phase.
- `irq_o`  out  1  timer interrupt, level, registered.

## Operation
- Register map (word offsets):
  - 0x00 MTIME_LO (RW)
  - 0x04 MTIME_HI (RW)
  - 0x08 MTIMECMP_LO (RW)
  - 0x0C MTIMECMP_HI (RW)
  - 0x10 CTRL: bit0 EN; bits[15:8] PRESC; others RAZ/WI
  - 0x14 STATUS (RO): bit0 = current compare result `mtime >= mtimecmp`
- Access: `psel_i & penable_i`.
  - Writes commit at the clock edge ending the access phase.
  - Write byte lanes are gated by `pstrb_i`.
- `pslverr_o` = 1 when `paddr_i[1:0] != 0`, when offset > 0x14, or on a write to STATUS. An erroring access has no side effects and returns `prdata_o` = 0.
- Increment: when EN = 1 and a prescaler tick occurs, `mtime` increments by 1 as a full 64-bit value.
  - The carry crosses LO→HI in the same cycle.
  - The counter wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- Prescaler: 8-bit counter `pcnt`.
  - A tick occurs when `pcnt == PRESC`; `pcnt` then returns to 0, so the divide ratio is PRESC+1.
  - `pcnt` is cleared when EN = 0 and on any write to CTRL.
- Read snapshot: a read of MTIME_LO latches the current MTIME_HI into `hi_shadow`.
  - A read of MTIME_HI returns `hi_shadow`.
  - `hi_shadow` tracks live MTIME_HI until the first LO read after reset.
- Simultaneous software write and increment on `mtime`:
  - The written word takes the write data.
  - The increment is dropped that cycle for the whole 64-bit value; no partial carry.
- `irq_o` next = EN & (`mtime` >= `mtimecmp`), compared unsigned at 64 bits using the registered values.
- Reset values: `mtime` = 0, `mtimecmp` = all ones, CTRL = 0, `pcnt` = 0, `hi_shadow` = 0, `irq_o` = 0, `prdata_o` = 0, `pslverr_o` = 0.

## Timing
- APB: zero wait states. Setup phase in cycle N, access phase in cycle N+1. Read data and `pslverr_o` are combinational in N+1.
- A register write is visible to a read issued in the next transfer.
- `irq_o` latency:
  - Asserts 1 cycle after the compare becomes true.
  - Deasserts 1 cycle after a `mtimecmp` or `mtime` write makes it false, or after EN is cleared.
- Reset in mid-transfer: the pending write is discarded, all state returns to reset values on that edge, and `irq_o` is 0 the following cycle.
- Counter with PRESC = 0 and EN = 1: `mtime` increments every cycle, starting the cycle after EN is written.

## Configuration
- `ZEROHETI_TIMER_PRESCALER_EN` defined: the prescaler behaves as described above.
- `ZEROHETI_TIMER_PRESCALER_EN` undefined:
  - No `pcnt` logic.
  - `mtime` increments every cycle while EN = 1.
  - CTRL[15:8] reads 0 and ignores writes.

## Test plan
- Reset → read all six registers:
  - MTIME 0/0, MTIMECMP 0xFFFFFFFF/0xFFFFFFFF, CTRL 0, STATUS 0.
  - `irq_o` = 0 and `pslverr_o` = 0 throughout.
- Write MTIMECMP = 10, then CTRL = 0x1 (PRESC = 0) → `irq_o` rises exactly 1 cycle after `mtime` reaches 10. Writing MTIMECMP_LO = 100 drops `irq_o` on the next cycle.
- Write MTIME = 0x0000_0000_FFFF_FFFE, EN = 1, PRESC = 0 → after 2 cycles, reading LO then HI gives 0x0000_0000 and 0x0000_0001. Write MTIME = all ones → `mtime` wraps to 0.
- PRESC = 3, EN = 1 → `mtime` increments once every 4 cycles. Rewriting CTRL restarts the 4-cycle phase. With the macro undefined, the increment is every cycle and CTRL reads 0x1.
- Access offset 0x18, offset 0x02, and a write to STATUS → `pslverr_o` = 1, `prdata_o` = 0, no register change.
- Assert `rst_i` during the access phase of a write to MTIMECMP_LO → the write is discarded and MTIMECMP reads all ones after reset.

Source files
------------

// File: rtl/zeroheti_apb_timer.sv
// rtl/zeroheti_apb_timer.sv - RISC-V machine timer (mtime/mtimecmp) as a zero-wait-state APB slave
// Optional prescaler enabled by defining ZEROHETI_TIMER_PRESCALER_EN.
module zeroheti_apb_timer #(
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [31:0]          pwdata_i,
    input  logic [3:0]           pstrb_i,
    output logic [31:0]          prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic                 irq_o
);

    localparam logic [2:0] IdxMtimeLo = 3'd0;
    localparam logic [2:0] IdxMtimeHi = 3'd1;
    localparam logic [2:0] IdxCmpLo   = 3'd2;
    localparam logic [2:0] IdxCmpHi   = 3'd3;
    localparam logic [2:0] IdxCtrl    = 3'd4;
    localparam logic [2:0] IdxStatus  = 3'd5;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        en;
    logic [7:0]  presc;
    logic [31:0] hi_shadow;
    logic        snap_valid;
    logic        tick;

    logic [4:0]  addr;
    logic [2:0]  idx;
    logic        access;
    logic        bad;
    logic        wr;
    logic        rd;
    logic [31:0] wmask;
    logic [31:0] rdata;
    logic        cmp_hit;
    logic        unused_addr;

    assign addr        = paddr_i[4:0];
    assign idx         = addr[4:2];
    assign unused_addr = ^paddr_i[AddrWidth-1:5];
    assign access      = psel_i & penable_i;
    assign bad         = (addr[1:0] != 2'b00) | (idx > IdxStatus) | (pwrite_i & (idx == IdxStatus));
    assign wr          = access & pwrite_i & ~bad;
    assign rd          = access & ~pwrite_i & ~bad;
    assign wmask       = {{8{pstrb_i[3]}}, {8{pstrb_i[2]}}, {8{pstrb_i[1]}}, {8{pstrb_i[0]}}};
    assign cmp_hit     = (mtime >= mtimecmp);

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [31:0] mask);
        return (old & ~mask) | (data & mask);
    endfunction

`ifdef ZEROHETI_TIMER_PRESCALER_EN
    logic [7:0] pcnt;

    // A CTRL write restarts the divide phase, so no tick may fire in that cycle.
    assign tick = en & (pcnt == presc) & ~(wr & (idx == IdxCtrl));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt  <= '0;
            presc <= '0;
        end else begin
            if (!en || (wr && idx == IdxCtrl) || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 8'd1;
            end
            if (wr && idx == IdxCtrl && pstrb_i[1]) begin
                presc <= pwdata_i[15:8];
            end
        end
    end
`else
    assign tick  = en;
    assign presc = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime      <= '0;
            mtimecmp   <= '1;
            en         <= 1'b0;
            hi_shadow  <= '0;
            snap_valid <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            // A software write to either word suppresses the whole 64-bit increment.
            if (wr && idx == IdxMtimeLo) begin
                mtime[31:0] <= merge(mtime[31:0], pwdata_i, wmask);
            end else if (wr && idx == IdxMtimeHi) begin
                mtime[63:32] <= merge(mtime[63:32], pwdata_i, wmask);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (wr && idx == IdxCmpLo) begin
                mtimecmp[31:0] <= merge(mtimecmp[31:0], pwdata_i, wmask);
            end
            if (wr && idx == IdxCmpHi) begin
                mtimecmp[63:32] <= merge(mtimecmp[63:32], pwdata_i, wmask);
            end
            if (wr && idx == IdxCtrl && pstrb_i[0]) begin
                en <= pwdata_i[0];
            end
            if (rd && idx == IdxMtimeLo) begin
                hi_shadow  <= mtime[63:32];
                snap_valid <= 1'b1;
            end
            irq_o <= en & cmp_hit;
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            IdxMtimeLo: rdata = mtime[31:0];
            IdxMtimeHi: rdata = snap_valid ? hi_shadow : mtime[63:32];
            IdxCmpLo:   rdata = mtimecmp[31:0];
            IdxCmpHi:   rdata = mtimecmp[63:32];
            IdxCtrl:    rdata = {16'h0000, presc, 7'b0000000, en};
            IdxStatus:  rdata = {31'b0, cmp_hit};
            default:    rdata = '0;
        endcase
    end

    assign prdata_o  = rd ? rdata : '0;
    assign pslverr_o = access & bad;
    assign pready_o  = 1'b1;

endmodule

// File: tb/tb_zeroheti_apb_timer.sv
// tb/tb_zeroheti_apb_timer.sv - scoreboard bench for zeroheti_apb_timer
module tb_zeroheti_apb_timer;

`ifdef ZEROHETI_TIMER_PRESCALER_EN
    localparam bit Pre = 1'b1;
`else
    localparam bit Pre = 1'b0;
`endif

    typedef struct {
        logic        is_read;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;
    logic        probe;
    logic        done;
    logic        end_checked;

    exp_t apb_q[$];
    logic irq_q[$];
    int   compared;
    int   mismatched;

    zeroheti_apb_timer #(.AddrWidth(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .pstrb_i   (pstrb),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] ed, input logic ee);
        exp_t e;
        e.is_read = !w;
        e.addr    = a;
        e.data    = ed;
        e.err     = ee;
        apb_q.push_back(e);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        apb(1'b1, a, d, 4'hF, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ed);
        apb(1'b0, a, 32'h0, 4'h0, ed, 1'b0);
    endtask

    task automatic probe_irq(input logic exp);
        irq_q.push_back(exp);
        probe = 1'b1;
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic ei;
        if (psel && penable && !rst) begin
            compared++;
            if (pready !== 1'b1) begin
                mismatched++;
                $display("FAIL pready: got %b want 1", pready);
            end
            if (apb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL apb_unexpected: got access at %h want none", paddr);
            end else begin
                e = apb_q.pop_front();
                compared++;
                if (pslverr !== e.err) begin
                    mismatched++;
                    $display("FAIL pslverr @%h: got %b want %b", e.addr, pslverr, e.err);
                end
                if (e.is_read) begin
                    compared++;
                    if (prdata !== e.data) begin
                        mismatched++;
                        $display("FAIL rdata @%h: got %h want %h", e.addr, prdata, e.data);
                    end
                end
            end
        end
        if (probe) begin
            compared++;
            if (irq_q.size() == 0) begin
                mismatched++;
                $display("FAIL irq_unexpected: got probe want none");
            end else begin
                ei = irq_q.pop_front();
                if (irq !== ei) begin
                    mismatched++;
                    $display("FAIL irq: got %b want %b", irq, ei);
                end
            end
        end
        if (done && !end_checked) begin
            end_checked = 1'b1;
            compared++;
            if (apb_q.size() != 0 || irq_q.size() != 0) begin
                mismatched++;
                $display("FAIL queue_drain: got %0d/%0d left want 0/0", apb_q.size(), irq_q.size());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        compared    = 0;
        mismatched  = 0;
        end_checked = 1'b0;
        done    = 1'b0;
        probe   = 1'b0;
        rst     = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset values
        rd(32'h00, 32'h0);
        rd(32'h04, 32'h0);
        rd(32'h08, 32'hFFFF_FFFF);
        rd(32'h0C, 32'hFFFF_FFFF);
        rd(32'h10, 32'h0);
        rd(32'h14, 32'h0);
        probe_irq(1'b0);

        // irq timing with PRESC = 0
        wr(32'h08, 32'd10);
        wr(32'h0C, 32'd0);
        wr(32'h10, 32'h1);
        idle(9);
        probe_irq(1'b0);
        probe_irq(1'b0);
        probe_irq(1'b1);
        rd(32'h14, 32'h1);
        wr(32'h08, 32'd100);
        probe_irq(1'b1);
        probe_irq(1'b0);
        rd(32'h00, 32'd19);
        rd(32'h04, 32'h0);

        // carry LO -> HI
        wr(32'h10, 32'h0);
        wr(32'h00, 32'hFFFF_FFFE);
        wr(32'h04, 32'h0);
        wr(32'h10, 32'h1);
        idle(1);
        rd(32'h00, 32'h0);
        rd(32'h04, 32'h1);

        // write wins over increment
        wr(32'h00, 32'h100);
        rd(32'h00, 32'h101);

        // 64-bit wrap
        wr(32'h10, 32'h0);
        wr(32'h00, 32'hFFFF_FFFF);
        wr(32'h04, 32'hFFFF_FFFF);
        wr(32'h10, 32'h1);
        rd(32'h00, 32'h0);
        rd(32'h04, 32'h0);

        // prescaler PRESC = 3 and phase restart
        wr(32'h10, 32'h0);
        wr(32'h00, 32'h0);
        wr(32'h04, 32'h0);
        wr(32'h10, 32'h301);
        rd(32'h10, Pre ? 32'h301 : 32'h1);
        rd(32'h00, Pre ? 32'd0 : 32'd3);
        rd(32'h00, Pre ? 32'd1 : 32'd5);
        rd(32'h00, Pre ? 32'd1 : 32'd7);
        wr(32'h10, 32'h301);
        rd(32'h00, Pre ? 32'd2 : 32'd11);
        rd(32'h00, Pre ? 32'd2 : 32'd13);

        // error responses, no side effects
        wr(32'h10, 32'h0);
        apb(1'b0, 32'h18, 32'h0, 4'h0, 32'h0, 1'b1);
        apb(1'b0, 32'h02, 32'h0, 4'h0, 32'h0, 1'b1);
        apb(1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        apb(1'b1, 32'h0A, 32'h1234, 4'hF, 32'h0, 1'b1);
        apb(1'b1, 32'h11, 32'h1, 4'hF, 32'h0, 1'b1);
        apb(1'b1, 32'h1C, 32'h1, 4'hF, 32'h0, 1'b1);
        rd(32'h08, 32'd100);
        rd(32'h10, 32'h0);
        rd(32'h14, 32'h0);

        // byte strobes
        apb(1'b1, 32'h0C, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
        rd(32'h0C, 32'h00BB_00DD);

        // reset during the access phase of a write
        wr(32'h08, 32'h0);
        wr(32'h0C, 32'h0);
        wr(32'h10, 32'h1);
        idle(1);
        probe_irq(1'b1);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h08;
        pwdata  = 32'h55;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        probe_irq(1'b0);
        rd(32'h08, 32'hFFFF_FFFF);
        rd(32'h0C, 32'hFFFF_FFFF);
        rd(32'h10, 32'h0);
        rd(32'h00, 32'h0);

        done = 1'b1;
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
